// File: rtl/vram_hex_writer_pkg.sv
// Shared constants for the text-mode VRAM writers: screen geometry, FSM
// encoding and the ASCII codes used when rendering hex values.
package vram_hex_writer_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 60;
  localparam int VRAM_CELLS = TEXT_COLS * TEXT_ROWS;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PFX0 = 3'd1;
  localparam logic [2:0] ST_PFX1 = 3'd2;
  localparam logic [2:0] ST_DIG  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_X     = 8'h78;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_UA    = 8'h41;
  localparam logic [7:0] ASC_LA    = 8'h61;

  // Index of the most significant digit to print; 0 and >8 both mean all eight.
  function automatic logic [2:0] ndig_to_idx(input logic [3:0] ndig);
    if (ndig == 4'd0 || ndig > 4'd8) return 3'd7;
    return 3'(ndig - 4'd1);
  endfunction

endpackage

// File: rtl/vram_hex_writer_hex2ascii.sv
// Nibble to ASCII hex character, purely combinational; usable by any screen writer.
module vram_hex_writer_hex2ascii
  import vram_hex_writer_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       upper,
  output logic [7:0] ch
);

  always_comb begin
    if (nib < 4'd10) ch = ASC_ZERO + {4'd0, nib};
    else             ch = (upper ? ASC_UA : ASC_LA) + {4'd0, nib} - 8'd10;
  end

endmodule

// File: rtl/vram_hex_writer.sv
// Renders a 32-bit value as ASCII hex into the character VRAM, one cell per clock,
// with optional "0x" prefix and leading-zero suppression.
module vram_hex_writer #(
  parameter int VRAM_AW    = 13,
  parameter int VRAM_CELLS = 4800,
  parameter int UPPER_CASE = 1
) (
  input  logic               clk,
  input  logic               RSTN,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_value,
  input  logic [VRAM_AW-1:0] req_addr,
  input  logic [3:0]         req_ndig,
  input  logic               req_prefix,
  input  logic               req_zsup,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_write_addr,
  output logic [7:0]         vram_data_in,
  output logic               busy,
  output logic               done
);
  import vram_hex_writer_pkg::*;

  logic [2:0]         state, nxt_state;
  logic [2:0]         idx, nxt_idx, dsel;
  logic [31:0]        val_q;
  logic               zsup_q, seen_q, nxt_seen;
  logic [VRAM_AW-1:0] addr_q, nxt_addr, addr_inc;
  logic [7:0]         data_q, nxt_data;
  logic               hs;
  logic [31:0]        src_val;
  logic               src_zsup, src_seen;
  logic [3:0]         nib;
  logic [7:0]         hex_ch, dig_char;
  logic               dig_seen;

  assign req_ready = (state == ST_IDLE) & RSTN;
  assign hs        = req_valid & req_ready;

  // During the handshake the first character comes straight from the request
  // inputs, so the first write lands in the very next cycle.
  assign src_val  = hs ? req_value : val_q;
  assign src_zsup = hs ? req_zsup  : zsup_q;
  assign src_seen = hs ? 1'b0      : seen_q;

  // idx is the digit currently on the outputs; dsel is the digit to emit next.
  always_comb begin
    case (state)
      ST_IDLE: dsel = ndig_to_idx(req_ndig);
      ST_DIG:  dsel = idx - 3'd1;
      default: dsel = idx;
    endcase
  end

  assign nib = src_val[{dsel, 2'b00} +: 4];

  vram_hex_writer_hex2ascii u_hex (
    .nib   (nib),
    .upper (UPPER_CASE != 0),
    .ch    (hex_ch)
  );

  assign dig_char = (src_zsup && !src_seen && nib == 4'd0 && dsel != 3'd0) ? ASC_SPACE : hex_ch;
  assign dig_seen = src_seen | (nib != 4'd0);
  assign addr_inc = (addr_q == VRAM_AW'(VRAM_CELLS - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_seen  = seen_q;
    nxt_addr  = addr_q;
    nxt_data  = data_q;
    case (state)
      ST_IDLE: if (hs) begin
        nxt_idx  = dsel;
        nxt_addr = req_addr;
        if (req_prefix) begin
          nxt_state = ST_PFX0;
          nxt_data  = ASC_ZERO;
          nxt_seen  = 1'b0;
        end else begin
          nxt_state = ST_DIG;
          nxt_data  = dig_char;
          nxt_seen  = dig_seen;
        end
      end
      ST_PFX0: begin
        nxt_state = ST_PFX1;
        nxt_data  = ASC_X;
        nxt_addr  = addr_inc;
      end
      ST_PFX1: begin
        nxt_state = ST_DIG;
        nxt_data  = dig_char;
        nxt_seen  = dig_seen;
        nxt_addr  = addr_inc;
      end
      ST_DIG: begin
        if (idx == 3'd0) nxt_state = ST_FIN;
        else begin
          nxt_idx  = dsel;
          nxt_data = dig_char;
          nxt_seen = dig_seen;
          nxt_addr = addr_inc;
        end
      end
      ST_FIN:  nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state  <= ST_IDLE;
      idx    <= '0;
      val_q  <= '0;
      zsup_q <= 1'b0;
      seen_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= nxt_state;
      idx    <= nxt_idx;
      seen_q <= nxt_seen;
      addr_q <= nxt_addr;
      data_q <= nxt_data;
      if (hs) begin
        val_q  <= req_value;
        zsup_q <= req_zsup;
      end
    end
  end

  assign vram_we         = (state == ST_PFX0) | (state == ST_PFX1) | (state == ST_DIG);
  assign vram_write_addr = addr_q;
  assign vram_data_in    = data_q;
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_FIN);

endmodule

// File: tb/tb_vram_hex_writer.sv
// Randomized bench for vram_hex_writer: upper- and lower-case instances share
// stimulus and are compared cycle by cycle against a string-level reference.
module tb_vram_hex_writer;

  logic        clk = 1'b0;
  logic        RSTN;
  logic        req_valid;
  logic [31:0] req_value;
  logic [12:0] req_addr;
  logic [3:0]  req_ndig;
  logic        req_prefix, req_zsup;

  logic        req_ready, vram_we, busy, done;
  logic [12:0] vram_write_addr;
  logic [7:0]  vram_data_in;
  logic        rdy_lc, we_lc, busy_lc, done_lc;
  logic [12:0] addr_lc;
  logic [7:0]  data_lc;

  int n_chk = 0;
  int n_fail = 0;
  int exp_a[$];
  int exp_u[$];
  int exp_l[$];

  always #5 clk = ~clk;

  vram_hex_writer #(.VRAM_AW(13), .VRAM_CELLS(4800), .UPPER_CASE(1)) dut (
    .clk(clk), .RSTN(RSTN), .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_addr(req_addr), .req_ndig(req_ndig),
    .req_prefix(req_prefix), .req_zsup(req_zsup), .vram_we(vram_we),
    .vram_write_addr(vram_write_addr), .vram_data_in(vram_data_in),
    .busy(busy), .done(done)
  );

  vram_hex_writer #(.VRAM_AW(13), .VRAM_CELLS(4800), .UPPER_CASE(0)) dut_lc (
    .clk(clk), .RSTN(RSTN), .req_valid(req_valid), .req_ready(rdy_lc),
    .req_value(req_value), .req_addr(req_addr), .req_ndig(req_ndig),
    .req_prefix(req_prefix), .req_zsup(req_zsup), .vram_we(we_lc),
    .vram_write_addr(addr_lc), .vram_data_in(data_lc),
    .busy(busy_lc), .done(done_lc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int asc(input int n, input bit up);
    if (n < 10) return 48 + n;
    return (up ? 65 : 97) + n - 10;
  endfunction

  // Reference: the list of (cell, character) pairs the request should produce.
  task automatic build(input logic [31:0] v, input int a, input int nd, input bit pfx, input bit zs);
    int n, nib, j;
    bit lead;
    exp_a.delete(); exp_u.delete(); exp_l.delete();
    n = (nd == 0 || nd > 8) ? 8 : nd;
    j = 0;
    if (pfx) begin
      exp_a.push_back(a % 4800);       exp_u.push_back(48);  exp_l.push_back(48);
      exp_a.push_back((a + 1) % 4800); exp_u.push_back(120); exp_l.push_back(120);
      j = 2;
    end
    lead = 1'b1;
    for (int k = n - 1; k >= 0; k--) begin
      nib = int'((v >> (4 * k)) & 32'hF);
      exp_a.push_back((a + j) % 4800);
      if (zs && lead && nib == 0 && k > 0) begin
        exp_u.push_back(32); exp_l.push_back(32);
      end else begin
        exp_u.push_back(asc(nib, 1'b1)); exp_l.push_back(asc(nib, 1'b0));
        lead = 1'b0;
      end
      j++;
    end
  endtask

  task automatic run_req(input logic [31:0] v, input int a, input int nd,
                         input bit pfx, input bit zs, input bit bp);
    int w;
    build(v, a, nd, pfx, zs);
    w = exp_a.size();
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_we", vram_we, 0);
    req_valid = 1'b1; req_value = v; req_addr = 13'(a);
    req_ndig = 4'(nd); req_prefix = pfx; req_zsup = zs;
    @(posedge clk);
    for (int c = 1; c <= w + 1; c++) begin
      @(negedge clk);
      check("busy_ready", req_ready, 0);
      check("busy", busy, 1);
      if (c <= w) begin
        check("we", vram_we, 1);
        check("we_lc", we_lc, 1);
        check("done_early", done, 0);
        check("addr", vram_write_addr, exp_a[c-1]);
        check("data", vram_data_in, exp_u[c-1]);
        check("data_lc", data_lc, exp_l[c-1]);
      end else begin
        check("fin_we", vram_we, 0);
        check("fin_done", done, 1);
        check("fin_done_lc", done_lc, 1);
        check("hold_addr", vram_write_addr, exp_a[w-1]);
        check("hold_data", vram_data_in, exp_u[w-1]);
      end
      if (bp) begin
        req_valid = 1'b1; req_value = $urandom; req_addr = 13'($urandom_range(0, 4799));
        req_ndig = 4'($urandom); req_prefix = 1'($urandom); req_zsup = 1'($urandom);
      end else req_valid = 1'b0;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; req_valid = 1'b0; req_value = '0; req_addr = '0;
    req_ndig = '0; req_prefix = 1'b0; req_zsup = 1'b0;
    #12;
    check("rst_we", vram_we, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", vram_write_addr, 0);
    check("rst_data", vram_data_in, 0);
    @(negedge clk); RSTN = 1'b1;

    run_req(32'h00401A2C, 100, 8, 1, 0, 0);
    run_req(32'h0000BEEF, 4798, 4, 0, 0, 0);
    run_req(32'h0000000F, 10, 8, 0, 1, 0);
    run_req(32'h00000000, 20, 8, 0, 1, 0);
    run_req(32'h12345678, 30, 0, 0, 0, 0);
    run_req(32'h12345678, 40, 12, 0, 0, 0);
    run_req(32'h0000000A, 50, 1, 0, 0, 1);
    run_req(32'hDEAD00F0, 4799, 8, 1, 1, 1);
    run_req(32'h00000005, 60, 3, 1, 1, 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] v;
      int a;
      v = $urandom >> $urandom_range(0, 31);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(4790, 4799) : $urandom_range(0, 4799);
      run_req(v, a, $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    go_idle();

    // Abandon an 8-digit request right after its third write.
    build(32'h12345678, 200, 8, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_value = 32'h12345678; req_addr = 13'd200;
    req_ndig = 4'd8; req_prefix = 1'b0; req_zsup = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("pre_rst_data", vram_data_in, exp_u[c-1]);
    end
    RSTN = 1'b0;
    #1;
    check("mid_rst_we", vram_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", req_ready, 0);
    repeat (3) begin
      @(negedge clk);
      check("in_rst_we", vram_we, 0);
      check("in_rst_done", done, 0);
    end
    RSTN = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("post_rst_we", vram_we, 0);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_ready", req_ready, 1);
    end
    run_req(32'h00C0FFEE, 300, 6, 1, 0, 0);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
